// File: rtl/pool_sched_pkg.sv
// pool_sched_pkg: shared states, default pooling geometry and pixel order.
// Used by pool_sched, rr_arbiter and pool_layer.
package pool_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    WAIT,
    RESP
  } state_t;

  localparam int POOL_DATA_W   = 32;
  localparam int POOL_WIN_SIZE = 4;
  localparam int POOL_AVG_LAT  = 3;

  localparam int PIX_TL = 0;
  localparam int PIX_TR = 1;
  localparam int PIX_BL = 2;
  localparam int PIX_BR = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from ptr+1
// upward with wrap; the pointer register lives in the caller.
module rr_arbiter
  import pool_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  // Walk offsets far-to-near so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int o = N; o >= 1; o--) begin
      c = (int'(ptr) + o) % N;
      if (req[c]) begin
        gnt = N'(1) << c;
        idx = IW'(c);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_sched.sv
// pool_sched: time-shares one avg_pool_unit between NUM_REQ requesters.
// Optional POOL_SCHED_PERF_EN adds svc_count/busy_cycles counters.
module pool_sched
  import pool_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = POOL_DATA_W,
  parameter int WIN_SIZE = POOL_WIN_SIZE,
  parameter int AVG_LAT  = POOL_AVG_LAT,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WIN_SIZE*DATA_W-1:0] req_win,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          resp_valid,
  output logic [ID_W-1:0]               resp_id,
  output logic [DATA_W-1:0]             resp_data,
  output logic                          busy,
  output logic [DATA_W-1:0]             pu_ip,
  output logic                          pu_en,
  output logic                          pu_rst,
  input  logic [DATA_W-1:0]             pu_op
`ifdef POOL_SCHED_PERF_EN
  ,
  output logic [31:0]                   svc_count,
  output logic [31:0]                   busy_cycles
`endif
);

  localparam int WB = WIN_SIZE * DATA_W;
  localparam int KW = (WIN_SIZE > 1) ? $clog2(WIN_SIZE) : 1;
  localparam int LW = (AVG_LAT > 1) ? $clog2(AVG_LAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIN_SIZE - 1);
  localparam logic [LW-1:0] L_LAST = LW'(AVG_LAT - 1);

  state_t            state_q, state_d;
  logic [WB-1:0]     win_q, win_d;
  logic [KW-1:0]     k_q, k_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_d;
  logic              resp_valid_d;
  logic [ID_W-1:0]   resp_id_d;
  logic [DATA_W-1:0] resp_data_d;
  logic              busy_d;
  logic [DATA_W-1:0] pu_ip_d;
  logic              pu_en_d;
  logic              pu_rst_d;

  logic [NUM_REQ-1:0] win_oh;
  logic [ID_W-1:0]    win_idx;
  logic               win_any;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    k_d          = k_q;
    lat_d        = lat_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    grant_d      = '0;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id;
    resp_data_d  = resp_data;
    pu_ip_d      = pu_ip;
    pu_en_d      = 1'b0;
    pu_rst_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d  = CLEAR;
          grant_d  = win_oh;
          owner_d  = win_idx;
          win_d    = req_win[int'(win_idx)*WB +: WB];
          pu_rst_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d = FEED;
        pu_en_d = 1'b1;
        k_d     = '0;
        pu_ip_d = win_q[PIX_TL*DATA_W +: DATA_W];
      end
      FEED: begin
        if (k_q == K_LAST) begin
          state_d = WAIT;
          lat_d   = '0;
        end else begin
          pu_en_d = 1'b1;
          k_d     = k_q + 1'b1;
          pu_ip_d = win_q[int'(k_d)*DATA_W +: DATA_W];
        end
      end
      WAIT: begin
        if (lat_q == L_LAST) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = pu_op;
          resp_id_d    = owner_q;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = owner_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      k_q        <= '0;
      lat_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      grant      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      busy       <= 1'b0;
      pu_ip      <= '0;
      pu_en      <= 1'b0;
      pu_rst     <= 1'b1;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      k_q        <= k_d;
      lat_q      <= lat_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      grant      <= grant_d;
      resp_valid <= resp_valid_d;
      resp_id    <= resp_id_d;
      resp_data  <= resp_data_d;
      busy       <= busy_d;
      pu_ip      <= pu_ip_d;
      pu_en      <= pu_en_d;
      pu_rst     <= pu_rst_d;
    end
  end

`ifdef POOL_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      svc_count   <= '0;
      busy_cycles <= '0;
    end else begin
      if (resp_valid)
        svc_count <= svc_count + 32'd1;
      if (busy && (busy_cycles != '1))
        busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_sched.sv
// tb_pool_sched: directed bench with a transaction-level scheduler model
// and an avg_pool_unit stub.
module tb_pool_sched;
  import pool_sched_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int WS  = 4;
  localparam int LAT = 3;
  localparam int IW  = 2;
  localparam int RESP_PH = 2 + WS + LAT;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*WS*DW-1:0] req_win;
  logic [N-1:0]      grant;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [DW-1:0]     resp_data;
  logic              busy;
  logic [DW-1:0]     pu_ip;
  logic              pu_en;
  logic              pu_rst;
  logic [DW-1:0]     pu_op;
`ifdef POOL_SCHED_PERF_EN
  logic [31:0]       svc_count;
  logic [31:0]       busy_cycles;
`endif

  always #5 clk = ~clk;

  pool_sched #(
    .NUM_REQ(N), .DATA_W(DW), .WIN_SIZE(WS), .AVG_LAT(LAT), .ID_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_win(req_win),
    .grant(grant), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .busy(busy), .pu_ip(pu_ip),
    .pu_en(pu_en), .pu_rst(pu_rst), .pu_op(pu_op)
`ifdef POOL_SCHED_PERF_EN
    , .svc_count(svc_count), .busy_cycles(busy_cycles)
`endif
  );

  // avg_pool_unit stub: accumulate on enable, avg = sum>>>2 after latency
  logic signed [DW+1:0] acc;
  logic [DW-1:0] p1, p2;
  always @(posedge clk) begin
    if (pu_rst) acc <= '0;
    else if (pu_en) acc <= acc + {{2{pu_ip[DW-1]}}, pu_ip};
    p1 <= DW'(acc >>> 2);
    p2 <= p1;
  end
  assign pu_op = p2;

  // Transaction model: ph = cycles since the selection edge, 0 = idle
  int ph, owner_m, ptr_m, cs;
  bit post_rst;
  int win_m [WS];
  int cyc = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph = 0; ptr_m = N - 1; post_rst = 1; owner_m = 0;
    end else begin
      post_rst = 0;
      if (ph == 0) begin
        if (req != 0) begin
          owner_m = -1;
          for (int o = 1; o <= N; o++) begin
            cs = (ptr_m + o) % N;
            if (owner_m < 0 && req[cs]) owner_m = cs;
          end
          for (int k = 0; k < WS; k++)
            win_m[k] = $signed(req_win[(owner_m*WS+k)*DW +: DW]);
          ph = 1;
        end
      end else if (ph == RESP_PH) begin
        ph = 0; ptr_m = owner_m;
      end else ph++;
    end
  end

  function automatic int exp_avg();
    longint s = 0;
    for (int k = 0; k < WS; k++) s += win_m[k];
    return int'(s >>> 2);
  endfunction

  int checks = 0, failures = 0;
  int g_id[$], g_cyc[$], r_id[$], r_cyc[$], r_data[$];
  int e_cyc;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic compare_cycle();
    bit feed;
    if (!rst) begin
      chk("rst_grant", grant, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pu_ip", pu_ip, 0);
      chk("rst_pu_en", pu_en, 0);
      chk("rst_pu_rst", pu_rst, 1);
    end else begin
      feed = (ph >= 2) && (ph <= WS + 1);
      chk("grant", grant, (ph == 1) ? (1 << owner_m) : 0);
      chk("busy", busy, ph != 0);
      chk("pu_en", pu_en, feed);
      chk("pu_rst", pu_rst, (ph == 1) || post_rst);
      chk("resp_valid", resp_valid, ph == RESP_PH);
      if (feed) chk("pu_ip", $signed(pu_ip), win_m[ph-2]);
      if (ph == RESP_PH) begin
        chk("resp_id", resp_id, owner_m);
        chk("resp_data", $signed(resp_data), exp_avg());
      end
    end
    if (grant != 0) begin
      g_id.push_back(oh_idx(grant)); g_cyc.push_back(cyc);
    end
    if (resp_valid) begin
      r_id.push_back(int'(resp_id)); r_cyc.push_back(cyc);
      r_data.push_back(int'($signed(resp_data)));
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic set_win(int i, int a, int b, int c, int d);
    int px [4];
    px = '{a, b, c, d};
    for (int k = 0; k < 4; k++)
      req_win[(i*WS+k)*DW +: DW] = DW'(px[k]);
  endtask

  task automatic wait_grant(output int id, output int rel);
    id = -1; rel = -1;
    for (int n = 0; n < 40 && id < 0; n++) begin
      step();
      if (grant != 0) begin
        id = oh_idx(grant); rel = cyc - e_cyc + 1;
      end
    end
    if (id < 0) begin
      checks++; failures++;
      $display("FAIL grant_timeout: got none expected a grant");
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 30 && !done; n++) begin
      step();
      if (!busy) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL idle_timeout: busy stuck at 1 expected 0");
    end
  endtask

  task automatic do_reset();
    step(); rst = 0; req = '0;
    step(); step(); rst = 1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish expected finish");
    $fatal(1);
  end

  int id, rel, gb, rb;
  int exp_px [4];
  int exp_ct [4];

  initial begin
    rst = 0; req = '0; req_win = '0;
    step(); step();
    chk("reset_pu_rst", pu_rst, 1);
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    rst = 1;
    step(); step();

    // single request, window change after capture is ignored
    set_win(0, 8, 4, -4, 0);
    rb = r_id.size();
    req = 4'b0001; e_cyc = cyc + 1;
    wait_grant(id, rel);
    chk("t1_grant_id", id, 0);
    chk("t1_grant_cycle", rel, 1);
    chk("t1_grant_vec", grant, 4'b0001);
    req = '0;
    set_win(0, 99, 99, 99, 99);
    exp_px = '{8, 4, -4, 0};
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_pu_en", pu_en, 1);
      chk("t1_pu_ip", $signed(pu_ip), exp_px[k]);
    end
    wait_idle();
    chk("t1_resp_count", r_id.size() - rb, 1);
    if (r_id.size() > rb) begin
      chk("t1_resp_cycle", r_cyc[rb] - e_cyc + 1, 9);
      chk("t1_resp_id", r_id[rb], 0);
      chk("t1_resp_data", r_data[rb], 2);
    end

    // contention: all four from the same edge
    do_reset();
    set_win(0, 1, 2, 3, 4);
    set_win(1, -1, -2, -3, -5);
    set_win(2, 100, 0, 0, 0);
    set_win(3, -8, -8, -8, -8);
    exp_ct = '{2, -3, 25, -8};
    rb = r_id.size();
    req = 4'b1111; e_cyc = cyc + 1;
    for (int s = 0; s < 4; s++) begin
      wait_grant(id, rel);
      chk("t2_grant_id", id, s);
      chk("t2_grant_cycle", rel, 1 + 10 * s);
      if (id >= 0) req[id] = 1'b0;
    end
    wait_idle();
    chk("t2_resp_count", r_id.size() - rb, 4);
    for (int s = 0; s < 4 && rb + s < r_id.size(); s++) begin
      chk("t2_resp_id", r_id[rb+s], s);
      chk("t2_resp_cycle", r_cyc[rb+s] - e_cyc + 1, 9 + 10 * s);
      chk("t2_resp_data", r_data[rb+s], exp_ct[s]);
    end

    // fairness: req0 and req2 held for six services
    do_reset();
    gb = g_id.size();
    req = 4'b0101; e_cyc = cyc + 1;
    for (int s = 0; s < 6; s++) begin
      wait_grant(id, rel);
      chk("t3_grant_id", id, (s % 2 == 1) ? 2 : 0);
    end
    req = '0;
    wait_idle();
    chk("t3_grant_count", g_id.size() - gb, 6);

    // req1 pulse during FEED is ignored
    do_reset();
    set_win(1, 5, 5, 5, 5);
    gb = g_id.size(); rb = r_id.size();
    req = 4'b0001; e_cyc = cyc + 1;
    wait_grant(id, rel);
    req = '0;
    step(); step();
    req = 4'b0010;
    step();
    req = '0;
    wait_idle();
    step(); step(); step();
    chk("t4_grant_count", g_id.size() - gb, 1);
    chk("t4_resp_count", r_id.size() - rb, 1);

    // reset in FEED aborts the window
    do_reset();
    rb = r_id.size();
    req = 4'b0001; e_cyc = cyc + 1;
    wait_grant(id, rel);
    req = '0;
    step();
    @(posedge clk); #1;
    rst = 0; #1;
    chk("t5_busy", busy, 0);
    chk("t5_pu_en", pu_en, 0);
    chk("t5_pu_ip", pu_ip, 0);
    chk("t5_pu_rst", pu_rst, 1);
    chk("t5_grant", grant, 0);
    step(); step();
    rst = 1;
    step(); step();
    req = 4'b0010; e_cyc = cyc + 1;
    wait_grant(id, rel);
    chk("t5_grant_id", id, 1);
    chk("t5_grant_cycle", rel, 1);
    chk("t5_grant_vec", grant, 4'b0010);
    req = '0;
    wait_idle();
    chk("t5_resp_count", r_id.size() - rb, 1);
    if (r_id.size() > rb) chk("t5_resp_id", r_id[rb], 1);

`ifdef POOL_SCHED_PERF_EN
    do_reset();
    chk("t6_svc_reset", svc_count, 0);
    req = 4'b0001; e_cyc = cyc + 1;
    for (int s = 0; s < 5; s++) wait_grant(id, rel);
    req = '0;
    wait_idle();
    step();
    chk("t6_svc_count", svc_count, 5);
    chk("t6_busy_cycles", busy_cycles, 45);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
